// File: rtl/v35_int_ack_seq_if.sv
// Word-read bus between the interrupt acknowledge sequencer and the bus unit.
// The sequencer is the master; the bus unit answers with mem_ready/mem_rdata.
interface v35_int_ack_seq_if;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/v35_int_ack_seq.sv
// V35-style interrupt acknowledge sequencer: two int_ack pulses, vector latch,
// then two word reads (IP, CS) from the real-mode vector table.
module v35_int_ack_seq #(
    parameter int unsigned ACK_LEN = 2,
    parameter int unsigned ACK_GAP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic                     boundary,
    input  logic                     int_req,
    output logic                     int_ack,
    input  logic [7:0]               int_vector,
    output logic                     busy,
    v35_int_ack_seq_if.master        mem,
    output logic                     vec_valid,
    output logic [15:0]              new_ip,
    output logic [15:0]              new_cs,
    output logic [7:0]               vector_out
);

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2,
        RD_IP,
        RD_CS,
        DONE
    } state_t;

    // The dwell counter counts down to zero, so it is loaded with length minus one.
    localparam logic [3:0] LEN_LOAD = 4'(ACK_LEN - 1);
    localparam logic [3:0] GAP_LOAD = 4'(ACK_GAP - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        int_ack_q, int_ack_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic [19:0] mem_addr_q, mem_addr_d;
    logic        vec_valid_q, vec_valid_d;
    logic [15:0] new_ip_q, new_ip_d;
    logic [15:0] new_cs_q, new_cs_d;
    logic [7:0]  vector_out_q, vector_out_d;

    function automatic logic [19:0] vecTableAddr(input logic [7:0] vec);
        return {10'b0, vec, 2'b00};
    endfunction

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        int_ack_d    = int_ack_q;
        busy_d       = busy_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        vec_valid_d  = vec_valid_q;
        new_ip_d     = new_ip_q;
        new_cs_d     = new_cs_q;
        vector_out_d = vector_out_q;

        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (boundary && int_req) begin
                        state_d   = ACK1;
                        cnt_d     = LEN_LOAD;
                        int_ack_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                ACK1: begin
                    if (cnt_q == 4'd0) begin
                        state_d   = GAP;
                        cnt_d     = GAP_LOAD;
                        int_ack_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 4'd0) begin
                        state_d   = ACK2;
                        cnt_d     = LEN_LOAD;
                        int_ack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ACK2: begin
                    // The vector is taken straight off the bus here because vector_out_q
                    // only updates at this same edge.
                    if (cnt_q == 4'd0) begin
                        state_d      = RD_IP;
                        cnt_d        = 4'd0;
                        int_ack_d    = 1'b0;
                        vector_out_d = int_vector;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = vecTableAddr(int_vector);
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RD_IP: begin
                    if (mem_req_q && mem.mem_ready) begin
                        state_d   = RD_CS;
                        cnt_d     = 4'd0;
                        new_ip_d  = mem.mem_rdata;
                        mem_req_d = 1'b0;
                    end
                end
                RD_CS: begin
                    // First cycle here is the mandatory idle bus cycle between the reads.
                    if (!mem_req_q) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = vecTableAddr(vector_out_q) + 20'd2;
                    end else if (mem.mem_ready) begin
                        state_d     = DONE;
                        cnt_d       = 4'd0;
                        new_cs_d    = mem.mem_rdata;
                        mem_req_d   = 1'b0;
                        vec_valid_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    vec_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            int_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 20'd0;
            vec_valid_q  <= 1'b0;
            new_ip_q     <= 16'd0;
            new_cs_q     <= 16'd0;
            vector_out_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            int_ack_q    <= int_ack_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            vec_valid_q  <= vec_valid_d;
            new_ip_q     <= new_ip_d;
            new_cs_q     <= new_cs_d;
            vector_out_q <= vector_out_d;
        end
    end

    assign int_ack      = int_ack_q;
    assign busy         = busy_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign vec_valid    = vec_valid_q;
    assign new_ip       = new_ip_q;
    assign new_cs       = new_cs_q;
    assign vector_out   = vector_out_q;

endmodule

// File: tb/tb_v35_int_ack_seq.sv
// Bench for v35_int_ack_seq: table-driven and random sequences against a memory
// model and an ack-pulse pattern derived from ACK_LEN/ACK_GAP.
module tb_v35_int_ack_seq;

    localparam int ACK_LEN = 2;
    localparam int ACK_GAP = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        boundary;
    logic        int_req;
    logic        int_ack;
    logic [7:0]  int_vector;
    logic        busy;
    logic        vec_valid;
    logic [15:0] new_ip;
    logic [15:0] new_cs;
    logic [7:0]  vector_out;

    v35_int_ack_seq_if memBus ();

    v35_int_ack_seq #(
        .ACK_LEN(ACK_LEN),
        .ACK_GAP(ACK_GAP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .boundary   (boundary),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .int_vector (int_vector),
        .busy       (busy),
        .mem        (memBus),
        .vec_valid  (vec_valid),
        .new_ip     (new_ip),
        .new_cs     (new_cs),
        .vector_out (vector_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  vec;
        logic [15:0] ip;
        logic [15:0] cs;
        int          waitIp;
        int          waitCs;
        int          ceMode;
        bit          dropReq;
        logic [19:0] expAddrIp;
        logic [19:0] expAddrCs;
    } vecRec_t;

    int total = 0;
    int bad   = 0;
    logic [15:0] memModel [logic [19:0]];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] outSnap();
        return {int_ack, busy, memBus.mem_req, memBus.mem_addr, vec_valid, new_ip, new_cs, vector_out};
    endfunction

    // Runs one full acknowledge sequence (or aborts it with reset during the CS read).
    task automatic applyStimulus(input vecRec_t r, input bit abortRdCs);
        logic [19:0] addrSeen [$];
        int          ackTrace [$];
        int          expTrace [$];
        logic [63:0] snap = '0;
        bit          lastCe = 1'b1;
        bit          ceNext;
        bit          started = 1'b0;
        bit          ackDone = 1'b0;
        bit          finished = 1'b0;
        bit          prevReq = 1'b0;
        int          reqRises = 0;
        int          waitCnt = 0;
        int          curWait;
        int          holdErr = 0;
        int          vvCycles = 0;
        int          vvChecked = 0;
        int          patErr = 0;

        memModel.delete();
        memModel[20'(r.vec) * 4]     = r.ip;
        memModel[20'(r.vec) * 4 + 2] = r.cs;
        int_vector = r.vec;

        for (int i = 0; i < ACK_LEN; i++) expTrace.push_back(1);
        for (int i = 0; i < ACK_GAP; i++) expTrace.push_back(0);
        for (int i = 0; i < ACK_LEN; i++) expTrace.push_back(1);

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0 && !lastCe && outSnap() !== snap) holdErr++;
            if (!started && busy) started = 1'b1;
            if (started && lastCe && !ackDone) begin
                if (memBus.mem_req) ackDone = 1'b1;
                else ackTrace.push_back(int'(int_ack));
            end
            if (memBus.mem_req && !prevReq) begin
                addrSeen.push_back(memBus.mem_addr);
                reqRises++;
            end
            if (abortRdCs && memBus.mem_req && reqRises == 2) begin
                #2 reset_n = 1'b0;
                #1 checkOutput("abortOutputs", outSnap(), 64'd0);
                checkOutput("abortNoVecValid", 64'(vvCycles), 64'd0);
                @(negedge clk);
                memBus.mem_ready = 1'b0;
                boundary = 1'b0;
                int_req = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (vec_valid && vvChecked == 0) begin
                vvChecked = 1;
                checkOutput("vvNewIp", 64'(new_ip), 64'(r.ip));
                checkOutput("vvNewCs", 64'(new_cs), 64'(r.cs));
                checkOutput("vvVector", 64'(vector_out), 64'(r.vec));
            end
            if (started && !busy) begin
                finished = 1'b1;
                break;
            end
            snap = outSnap();
            prevReq = memBus.mem_req;

            case (r.ceMode)
                0: ceNext = 1'b1;
                1: ceNext = ~lastCe;
                default: ceNext = ($urandom_range(0, 2) != 0);
            endcase
            ce = ceNext;
            if (!started) begin
                boundary = 1'b1;
                int_req = 1'b1;
            end else begin
                boundary = 1'($urandom_range(0, 1));
                int_req = r.dropReq ? 1'b0 : 1'b1;
            end
            curWait = (reqRises <= 1) ? r.waitIp : r.waitCs;
            if (memBus.mem_req) begin
                if (waitCnt >= curWait) begin
                    memBus.mem_ready = 1'b1;
                    memBus.mem_rdata = memModel.exists(memBus.mem_addr) ? memModel[memBus.mem_addr] : 16'hBAD0;
                end else begin
                    memBus.mem_ready = 1'b0;
                    memBus.mem_rdata = 16'hDEAD;
                    if (ceNext) waitCnt++;
                end
            end else begin
                waitCnt = 0;
                memBus.mem_ready = 1'($urandom_range(0, 1));
                memBus.mem_rdata = 16'hDEAD;
            end
            if (vec_valid && ceNext) vvCycles++;
            lastCe = ceNext;
            @(negedge clk);
        end

        boundary = 1'b0;
        int_req = 1'b0;
        memBus.mem_ready = 1'b0;
        ce = 1'b1;
        checkOutput("seqFinished", 64'(finished), 64'd1);
        checkOutput("ackTraceLen", 64'(ackTrace.size()), 64'(expTrace.size()));
        for (int i = 0; i < ackTrace.size() && i < expTrace.size(); i++)
            if (ackTrace[i] != expTrace[i]) patErr++;
        checkOutput("ackTracePattern", 64'(patErr), 64'd0);
        checkOutput("readCount", 64'(reqRises), 64'd2);
        if (addrSeen.size() == 2) begin
            checkOutput("addrIp", 64'(addrSeen[0]), 64'(r.expAddrIp));
            checkOutput("addrCs", 64'(addrSeen[1]), 64'(r.expAddrCs));
        end
        checkOutput("vecValidCycles", 64'(vvCycles), 64'd1);
        checkOutput("ceHold", 64'(holdErr), 64'd0);
        checkOutput("finalIp", 64'(new_ip), 64'(r.ip));
        checkOutput("finalCs", 64'(new_cs), 64'(r.cs));
        checkOutput("finalVector", 64'(vector_out), 64'(r.vec));
        checkOutput("finalQuiet", 64'({int_ack, memBus.mem_req, vec_valid}), 64'd0);
    endtask

    vecRec_t table_q [$];
    vecRec_t rec;

    initial begin
        reset_n = 1'b0;
        ce = 1'b0;
        boundary = 1'b0;
        int_req = 1'b0;
        int_vector = 8'h00;
        memBus.mem_ready = 1'b0;
        memBus.mem_rdata = 16'h0000;

        table_q.push_back('{8'h18, 16'h1234, 16'hABCD, 0, 0, 0, 1'b0, 20'h00060, 20'h00062});
        table_q.push_back('{8'h18, 16'h1234, 16'hABCD, 3, 3, 0, 1'b0, 20'h00060, 20'h00062});
        table_q.push_back('{8'hFF, 16'h5A5A, 16'h0F0F, 1, 2, 0, 1'b1, 20'h003FC, 20'h003FE});
        table_q.push_back('{8'h00, 16'hFFFF, 16'h0001, 2, 0, 1, 1'b0, 20'h00000, 20'h00002});
        table_q.push_back('{8'h81, 16'h8001, 16'h7FFE, 0, 5, 2, 1'b1, 20'h00204, 20'h00206});

        #1 checkOutput("resetState", outSnap(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ce = 1'b1;

        // Request without an instruction boundary must not start anything.
        int_req = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("noBoundaryBusy", 64'({busy, int_ack}), 64'd0);
        int_req = 1'b0;
        boundary = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("noReqBusy", 64'({busy, int_ack}), 64'd0);
        int_req = 1'b1;
        ce = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("ceLowIdle", 64'({busy, int_ack}), 64'd0);
        boundary = 1'b0;
        int_req = 1'b0;
        ce = 1'b1;
        @(negedge clk);

        foreach (table_q[i]) applyStimulus(table_q[i], 1'b0);

        // Reset during the CS read, then a clean run must follow.
        applyStimulus(table_q[1], 1'b1);
        checkOutput("postAbortIdle", 64'({busy, vec_valid, int_ack}), 64'd0);
        ce = 1'b1;
        @(negedge clk);
        applyStimulus(table_q[2], 1'b0);

        for (int n = 0; n < 6; n++) begin
            rec.vec     = 8'($urandom_range(0, 255));
            rec.ip      = 16'($urandom);
            rec.cs      = 16'($urandom);
            rec.waitIp  = $urandom_range(0, 4);
            rec.waitCs  = $urandom_range(0, 4);
            rec.ceMode  = $urandom_range(0, 2);
            rec.dropReq = 1'($urandom_range(0, 1));
            rec.expAddrIp = 20'(rec.vec) * 4;
            rec.expAddrCs = 20'(rec.vec) * 4 + 2;
            applyStimulus(rec, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
